// File: rtl/stream_xform_pipe.sv
// Elastic N-stage pipeline applying a per-beat transform on entry.
// Stages collapse bubbles; backpressure ripples back combinationally.
module stream_xform_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [15:0]      o_count
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [WIDTH-1:0]  xf;

    always_comb begin
        xf = i_data;
        unique case (i_mode)
            2'b01: xf = ~i_data;
            2'b10: xf = -i_data;
            2'b11: begin
                for (int k = 0; k < WIDTH; k++) begin
                    xf[k] = i_data[WIDTH-1-k];
                end
            end
            default: ;
        endcase
    end

    // A stage moves if any slot at or after it is empty, or the sink takes a beat.
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic a;
            a = i_ready;
            for (int j = k; j < STAGES; j++) begin
                a = a | ~vld[j];
            end
            adv[k] = a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld     <= '0;
            o_count <= '0;
        end else begin
            if (adv[0]) vld[0] <= i_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) vld[k] <= vld[k-1];
            end
            if (o_valid && i_ready) o_count <= o_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv[0]) dat[0] <= xf;
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) dat[k] <= dat[k-1];
        end
    end

    assign o_ready = adv[0];
    assign o_valid = vld[STAGES-1];
    assign o_data  = dat[STAGES-1];

endmodule

// File: tb/tb_stream_xform_pipe.sv
// Bench for stream_xform_pipe: directed checks on a 3-stage pipe plus
// randomized scoreboarding of 1- and 8-stage pipes.
module tb_stream_xform_pipe;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic [1:0]  i_mode;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic [15:0] o_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dlv = 0;
    bit lat_on = 0;
    logic [7:0] q[$];
    int qc[$];
    bit hold_pend = 0;
    logic [7:0] hold_d;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    stream_xform_pipe #(.WIDTH(8), .STAGES(3)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_mode(i_mode),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_count(o_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_xf(input logic [7:0] d,
                                          input logic [1:0] m);
        int x;
        int r;
        x = int'(d);
        r = 0;
        case (m)
            2'd0: r = x;
            2'd1: r = 255 - x;
            2'd2: r = (256 - x) % 256;
            default: begin
                for (int i = 0; i < 8; i++) begin
                    r = r * 2 + (x % 2);
                    x = x / 2;
                end
            end
        endcase
        return 8'(r);
    endfunction

    // Scoreboard for the 3-stage pipe
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            qc.delete();
            hold_pend = 0;
            dlv = 0;
        end else begin
            if (hold_pend && o_valid) chk("hold", 32'(o_data), 32'(hold_d));
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 32'(q.size()), 32'd1);
                end else begin
                    chk("data", 32'(o_data), 32'(q.pop_front()));
                    if (lat_on) chk("latency", 32'(cyc - qc[0]), 32'd3);
                    void'(qc.pop_front());
                end
                dlv++;
            end
            hold_pend = o_valid && !i_ready;
            hold_d = o_data;
            if (i_valid && o_ready) begin
                q.push_back(ref_xf(i_data, i_mode));
                qc.push_back(cyc);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int S = (g == 0) ? 1 : 8;
        logic        rr;
        logic        v;
        logic        rdy;
        logic [7:0]  d;
        logic [1:0]  m;
        logic        ovv;
        logic        r;
        logic [7:0]  od;
        logic [15:0] cnt;
        logic [7:0]  sq[$];
        int          nd;
        bit          done;

        stream_xform_pipe #(.WIDTH(8), .STAGES(S)) dut_r (
            .clk(clk), .reset(rr),
            .i_valid(v), .o_ready(rdy),
            .i_data(d), .i_mode(m),
            .o_valid(ovv), .i_ready(r),
            .o_data(od), .o_count(cnt)
        );

        initial begin
            rr = 0; v = 0; r = 0; d = 0; m = 0; nd = 0; done = 0;
            #23 rr = 1;
            for (int i = 0; i < 3000; i++) begin
                @(posedge clk); #1;
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) != 0);
                d = 8'($urandom);
                m = 2'($urandom);
            end
            v = 0;
            r = 1;
            repeat (S + 4) @(posedge clk);
            #1;
            chk("rnd_left", 32'(sq.size()), 32'd0);
            chk("rnd_cnt", 32'(cnt), 32'(16'(nd)));
            done = 1;
        end

        always @(negedge clk) begin
            if (rr) begin
                if (ovv && r) begin
                    if (sq.size() == 0) chk("rnd_extra", 32'(sq.size()), 32'd1);
                    else chk("rnd_data", 32'(od), 32'(sq.pop_front()));
                    nd++;
                end
                if (v && rdy) sq.push_back(ref_xf(d, m));
            end
        end
    end

    initial begin
        logic [7:0] tin  [6];
        logic [1:0] tmd  [6];
        logic [7:0] tout [6];
        int n;
        int acc;
        logic [15:0] base;
        tin  = '{8'h0F, 8'h01, 8'h80, 8'h00, 8'h01, 8'hA5};
        tmd  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
        tout = '{8'hF0, 8'hFF, 8'h80, 8'h00, 8'h80, 8'hA5};

        reset = 0; i_valid = 0; i_ready = 1; i_data = 0; i_mode = 0;
        #1;
        chk("rst_ov", 32'(o_valid), 32'd0);
        chk("rst_cnt", 32'(o_count), 32'd0);
        chk("rst_rdy", 32'(o_ready), 32'd1);
        #20;
        @(posedge clk); #1;
        reset = 1;

        // transform table, back-to-back with no stall
        lat_on = 1;
        n = 0;
        for (int t = 0; t < 10; t++) begin
            if (t < 6) begin
                i_valid = 1; i_data = tin[t]; i_mode = tmd[t];
            end else begin
                i_valid = 0;
            end
            @(negedge clk);
            if (o_valid && n < 6) begin
                chk("mode", 32'(o_data), 32'(tout[n]));
                n++;
            end
            @(posedge clk); #1;
        end
        lat_on = 0;
        chk("mode_n", 32'(n), 32'd6);
        chk("mode_cnt", 32'(o_count), 32'd6);

        // full stall
        i_ready = 0;
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            i_valid = 1; i_data = 8'($urandom); i_mode = 2'($urandom);
            @(negedge clk);
            if (o_ready) acc++;
            @(posedge clk); #1;
        end
        i_valid = 0;
        @(negedge clk);
        chk("stall_acc", 32'(acc), 32'd3);
        chk("stall_rdy", 32'(o_ready), 32'd0);
        chk("stall_ov", 32'(o_valid), 32'd1);
        base = o_count;
        @(posedge clk); #1;
        i_ready = 1;
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_cnt", 32'(o_count), 32'(16'(base + 16'd3)));
        chk("stall_q", 32'(q.size()), 32'd0);

        // single beat walks forward while the sink is blocked
        i_ready = 0;
        i_valid = 1; i_data = 8'h3C; i_mode = 2'b01;
        @(negedge clk);
        chk("bub_acc", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk("bub_rdy", 32'(o_ready), 32'd1);
            if (t < 3) begin
                chk("bub_ov_early", 32'(o_valid), 32'd0);
            end else begin
                chk("bub_ov", 32'(o_valid), 32'd1);
                chk("bub_data", 32'(o_data), 32'hC3);
            end
            @(posedge clk); #1;
        end
        i_ready = 1;
        repeat (2) begin @(posedge clk); #1; end

        // reset with beats in flight
        i_ready = 0;
        for (int t = 0; t < 4; t++) begin
            i_valid = 1; i_data = 8'($urandom); i_mode = 2'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_ov", 32'(o_valid), 32'd1);
        @(posedge clk); #3;
        reset = 0;
        i_valid = 0;
        #1;
        chk("rst2_ov", 32'(o_valid), 32'd0);
        chk("rst2_cnt", 32'(o_count), 32'd0);
        chk("rst2_rdy", 32'(o_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        i_ready = 1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("stale", 32'(o_valid), 32'd0);
            @(posedge clk); #1;
        end
        i_valid = 1; i_data = 8'h5A; i_mode = 2'b11;
        @(negedge clk);
        chk("first_acc", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        chk("first_cnt", 32'(o_count), 32'd1);

        // counter wrap
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        i_valid = 1;
        i_ready = 1;
        for (int i = 0; i < 70000 && dlv < 65535; i++) begin
            i_data = 8'($urandom); i_mode = 2'($urandom);
            @(posedge clk); #1;
        end
        chk("wrap_ffff", 32'(o_count), 32'h0000FFFF);
        for (int i = 0; i < 10 && dlv < 65536; i++) begin
            i_data = 8'($urandom); i_mode = 2'($urandom);
            @(posedge clk); #1;
        end
        chk("wrap_zero", 32'(o_count), 32'd0);
        i_valid = 0;
        repeat (6) begin @(posedge clk); #1; end
        chk("wrap_q", 32'(q.size()), 32'd0);

        for (int i = 0; i < 100 && !(g_rnd[0].done && g_rnd[1].done); i++)
            @(posedge clk);
        chk("rnd_done", 32'(g_rnd[0].done && g_rnd[1].done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_xform_pipe.md
STREAM_XFORM_PIPE -- requirements
Module: stream_xform_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits; legal range is 1 or more.
REQ-002 The block SHALL have parameter STAGES, default 2, pipeline depth in register stages; legal range is 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: upstream beat valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port i_data, input, WIDTH bits: upstream payload.
REQ-008 The block SHALL have port i_mode, input, 2 bits: transform for this beat, sampled together with i_data.
REQ-009 The block SHALL have port o_valid, output, 1 bit: downstream beat valid.
REQ-010 The block SHALL have port i_ready, input, 1 bit: downstream accepts a beat.
REQ-011 The block SHALL have port o_data, output, WIDTH bits: transformed payload.
REQ-012 The block SHALL have port o_count, output, 16 bits: count of completed output beats.

Function
REQ-013 A beat SHALL be accepted in a cycle where i_valid=1 and o_ready=1, and delivered in a cycle where o_valid=1 and i_ready=1.
REQ-014 The transform SHALL be applied per beat from its own i_mode: 00 pass, 01 bitwise NOT, 10 two's-complement negate mod 2^WIDTH, 11 bit-reverse (o[k]=i[WIDTH-1-k]).
REQ-015 The transformed value SHALL be registered into stage 0 on acceptance; no combinational path SHALL exist from i_data/i_mode to o_data.
REQ-016 Each stage k SHALL hold a valid bit and a WIDTH-bit data register; o_valid/o_data SHALL come directly from stage STAGES-1.
REQ-017 The last stage SHALL advance when it is empty or i_ready=1; stage k<STAGES-1 SHALL advance when it is empty or stage k+1 advances (bubble-collapsing).
REQ-018 o_ready SHALL equal the stage-0 advance condition; it MAY depend combinationally on i_ready.
REQ-019 When a stage advances, it SHALL load the previous stage's valid/data; stage 0 SHALL load i_valid and the transformed data; a stage that loads an empty slot SHALL become invalid.
REQ-020 A non-advancing stage SHALL hold its valid bit and data unchanged, so o_data stays stable while o_valid=1 and i_ready=0.
REQ-021 Latency with no stall SHALL be exactly STAGES cycles from the acceptance edge to o_valid; throughput SHALL be 1 beat/cycle.
REQ-022 Under full stall the block SHALL hold exactly STAGES beats, with o_ready=0; no beat SHALL be lost, duplicated or reordered.
REQ-023 A beat sitting behind an empty downstream stage SHALL move forward every cycle even while i_ready=0.
REQ-024 Simultaneous delivery at the output and acceptance at the input SHALL be permitted whenever the chain advances.
REQ-025 o_count SHALL increment by 1 on each delivered beat and wrap from 16'hFFFF to 0.
REQ-026 Data registers need not be reset; a valid bit of 0 SHALL mask them.

Reset
REQ-027 Asserting reset (low) SHALL immediately, without a clock, clear all stage valid bits and o_count to 0, giving o_valid=0.
REQ-028 During reset, o_ready SHALL read 1.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after release.
REQ-030 The first beat after reset release SHALL be accepted on the first rising edge with i_valid=1.

Verification (WIDTH=8, STAGES=3 unless stated)
REQ-031 Reset: drive reset=0 mid-stream -> o_valid=0, o_count=0, o_ready=1 asynchronously; after release no stale beat appears.
REQ-032 Modes, i_ready=1: inputs 0x0F/01, 0x01/10, 0x80/10, 0x00/10, 0x01/11, 0xA5/00 -> outputs 0xF0, 0xFF, 0x80, 0x00, 0x80, 0xA5, each exactly 3 cycles after acceptance, back-to-back.
REQ-033 Stall: i_ready=0 with i_valid=1 on a continuous stream -> exactly 3 beats accepted, then o_ready=0 and o_data held; raising i_ready drains them in order with o_count +3.
REQ-034 Bubble collapse: one beat with i_ready=0 -> beat reaches the last stage after 3 cycles, and o_ready stays 1 throughout.
REQ-035 Wrap: deliver 65536 beats -> o_count returns to 0; random valid/ready with STAGES=1 and STAGES=8 -> scoreboard shows no loss, duplication or reordering.
